// File: rtl/mod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod_pkg
// Description : Shared types and defaults for the modulation frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mod_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_GUARD    = 2'd3
  } state_t;

  localparam int   DEF_BIT_PERIOD    = 250000;
  localparam int   DEF_PREAMBLE_BITS = 8;
  localparam int   DEF_GUARD_BITS    = 4;

  // Level of the first preamble bit; subsequent bits alternate
  localparam logic PREAMBLE_START    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mod_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : mod_bit_timer
// Description : Bit-period counter. Counts 0..PERIOD-1 while enabled and
//               flags the last cycle of each period; held at 0 when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_bit_timer #(
  parameter int PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic strobe
);

  localparam int               CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] count;

  assign strobe = en && (count == LAST);

  // Free-running period counter, wraps straight back to 0 after the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mod_frame_seq.sv
`default_nettype none
// ============================================================================
// Module      : mod_frame_seq
// Description : Serial frame sequencer for a modulated carrier: preamble,
//               MSB-first payload bytes and a guard interval, plus carrier
//               enable, latched mode and AM depth.
//               Optional macro MOD_DEPTH_RAMP_EN: depth ramps 1 LSB/clk up
//               toward depth_tgt and back to 0 during GUARD (GUARD extended
//               until the depth reaches 0).
// Revision    : 1.0 - initial release
// ============================================================================
module mod_frame_seq
  import mod_pkg::*;
#(
  parameter int BIT_PERIOD    = DEF_BIT_PERIOD,
  parameter int PREAMBLE_BITS = DEF_PREAMBLE_BITS,
  parameter int GUARD_BITS    = DEF_GUARD_BITS,
  parameter int DEPTH_W       = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         byte_data,
  input  logic               byte_valid,
  input  logic               byte_last,
  output logic               byte_ready,
  input  logic               mode_fsk,
  input  logic [DEPTH_W-1:0] depth_tgt,
  output logic               bit_out,
  output logic               bit_strobe,
  output logic               carrier_en,
  output logic               mode_lat,
  output logic [DEPTH_W-1:0] depth_out,
  output logic               busy,
  output logic               frame_done,
  output logic               underrun
);

  // Remaining-bit counters are loaded with "bits - 1" and count down to 0
  localparam logic [7:0] PRE_LAST = (PREAMBLE_BITS == 0) ? 8'd0 : 8'(PREAMBLE_BITS - 1);
  localparam logic [7:0] GRD_LAST = 8'(GUARD_BITS - 1);

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       last_held;
  logic [7:0] pre_left;
  logic [7:0] grd_left;
  logic       idle_rdy;
  logic       strobe;
  logic       data_rdy;
  logic       accept;
  logic       depth_zero;
  logic       guard_exit;

  mod_bit_timer #(
    .PERIOD (BIT_PERIOD)
  ) u_bit_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (busy),
    .strobe (strobe)
  );

  assign busy       = (state != ST_IDLE);
  assign bit_strobe = strobe;
  // Next byte can only be taken on the final bit boundary of a non-last byte
  assign data_rdy   = (state == ST_DATA) && (bit_idx == 3'd0) && strobe && !last_held;
  assign byte_ready = idle_rdy || data_rdy;
  assign accept     = (state == ST_IDLE) && idle_rdy && byte_valid;

`ifdef MOD_DEPTH_RAMP_EN
  assign depth_zero = (depth_out == '0);
`else
  assign depth_zero = 1'b1;
`endif

  assign guard_exit = (state == ST_GUARD) && strobe && (grd_left == 8'd0) && depth_zero;

  // Frame sequencing FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shreg      <= 8'd0;
      bit_idx    <= 3'd0;
      last_held  <= 1'b0;
      pre_left   <= 8'd0;
      grd_left   <= 8'd0;
      idle_rdy   <= 1'b0;
      bit_out    <= 1'b1;
      carrier_en <= 1'b0;
      mode_lat   <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        ST_IDLE: begin
          idle_rdy <= 1'b1;
          if (accept) begin
            shreg      <= byte_data;
            last_held  <= byte_last;
            mode_lat   <= mode_fsk;
            carrier_en <= 1'b1;
            idle_rdy   <= 1'b0;
            pre_left   <= PRE_LAST;
            bit_idx    <= 3'd7;
            if (PREAMBLE_BITS == 0) begin
              state   <= ST_DATA;
              bit_out <= byte_data[7];
            end else begin
              state   <= ST_PREAMBLE;
              bit_out <= PREAMBLE_START;
            end
          end
        end
        ST_PREAMBLE: begin
          if (strobe) begin
            if (pre_left == 8'd0) begin
              state   <= ST_DATA;
              bit_idx <= 3'd7;
              bit_out <= shreg[7];
            end else begin
              pre_left <= pre_left - 8'd1;
              bit_out  <= ~bit_out;
            end
          end
        end
        ST_DATA: begin
          if (strobe) begin
            if (bit_idx != 3'd0) begin
              bit_idx <= bit_idx - 3'd1;
              bit_out <= shreg[bit_idx - 3'd1];
            end else if (last_held) begin
              state    <= ST_GUARD;
              grd_left <= GRD_LAST;
              bit_out  <= 1'b1;
            end else if (byte_valid) begin
              // Back-to-back byte: continue without a gap bit
              shreg     <= byte_data;
              last_held <= byte_last;
              bit_idx   <= 3'd7;
              bit_out   <= byte_data[7];
            end else begin
              underrun <= 1'b1;
              state    <= ST_GUARD;
              grd_left <= GRD_LAST;
              bit_out  <= 1'b1;
            end
          end
        end
        ST_GUARD: begin
          bit_out <= 1'b1;
          if (guard_exit) begin
            state      <= ST_IDLE;
            carrier_en <= 1'b0;
            frame_done <= 1'b1;
            idle_rdy   <= 1'b1;
          end else if (strobe && (grd_left != 8'd0)) begin
            grd_left <= grd_left - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MOD_DEPTH_RAMP_EN
  // Depth slews 1 LSB per clock: toward the target while transmitting, to 0 in GUARD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_out <= '0;
    end else if (!carrier_en) begin
      depth_out <= '0;
    end else if (state == ST_GUARD) begin
      if (!depth_zero) depth_out <= depth_out - DEPTH_W'(1);
    end else if (depth_out < depth_tgt) begin
      depth_out <= depth_out + DEPTH_W'(1);
    end else if (depth_out > depth_tgt) begin
      depth_out <= depth_out - DEPTH_W'(1);
    end
  end
`else
  // Depth follows the target while the carrier will be on, else forced to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_out <= '0;
    end else if (accept || (busy && !guard_exit)) begin
      depth_out <= depth_tgt;
    end else begin
      depth_out <= '0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_frame_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_frame_seq
// Description : Directed self-checking bench for mod_frame_seq
//               (BIT_PERIOD=4, PREAMBLE_BITS=2, GUARD_BITS=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_frame_seq;

  localparam int BP = 4;
  localparam int PB = 2;
  localparam int GB = 1;
  localparam int DW = 9;
`ifdef MOD_DEPTH_RAMP_EN
  localparam logic [DW-1:0] TGT = 9'd0;
`else
  localparam logic [DW-1:0] TGT = 9'd100;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    byte_data = 8'd0;
  logic          byte_valid = 1'b0;
  logic          byte_last = 1'b0;
  logic          byte_ready;
  logic          mode_fsk = 1'b0;
  logic [DW-1:0] depth_tgt = '0;
  logic          bit_out;
  logic          bit_strobe;
  logic          carrier_en;
  logic          mode_lat;
  logic [DW-1:0] depth_out;
  logic          busy;
  logic          frame_done;
  logic          underrun;

  int n_checks = 0;
  int n_fail   = 0;

  mod_frame_seq #(
    .BIT_PERIOD    (BP),
    .PREAMBLE_BITS (PB),
    .GUARD_BITS    (GB),
    .DEPTH_W       (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .mode_fsk   (mode_fsk),
    .depth_tgt  (depth_tgt),
    .bit_out    (bit_out),
    .bit_strobe (bit_strobe),
    .carrier_en (carrier_en),
    .mode_lat   (mode_lat),
    .depth_out  (depth_out),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bit_out"},  bit_out,    1);
    check({tag, "_ready"},    byte_ready, 0);
    check({tag, "_carrier"},  carrier_en, 0);
    check({tag, "_mode_lat"}, mode_lat,   0);
    check({tag, "_depth"},    depth_out,  0);
    check({tag, "_busy"},     busy,       0);
    check({tag, "_strobe"},   bit_strobe, 0);
    check({tag, "_done"},     frame_done, 0);
    check({tag, "_underrun"}, underrun,   0);
  endtask

  initial begin
    int         seq_a [11] = '{1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    logic [7:0] b81 = 8'h81;
    logic       any_under;

    depth_tgt = TGT;

    // ---------------- reset ----------------
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    #1;
    check("rst_rel_ready_before_edge", byte_ready, 0);
    @(negedge clk);
    check("rst_rel_ready", byte_ready, 1);

    // ---------------- A: single last byte 0xA5 ----------------
    byte_data = 8'hA5; byte_last = 1'b1; byte_valid = 1'b1; mode_fsk = 1'b0;
    @(negedge clk);
    byte_valid = 1'b0;
    for (int k = 0; k <= 44; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 44) begin
        check($sformatf("A_bit_k%0d", k), bit_out, seq_a[k/4]);
        check($sformatf("A_strobe_k%0d", k), bit_strobe, (k % 4 == 3));
        check($sformatf("A_carrier_k%0d", k), carrier_en, 1);
        check($sformatf("A_depth_k%0d", k), depth_out, TGT);
      end
      check($sformatf("A_done_k%0d", k), frame_done, (k == 44));
    end
    check("A_end_busy", busy, 0);
    check("A_end_carrier", carrier_en, 0);
    check("A_end_depth", depth_out, 0);
    check("A_end_ready", byte_ready, 1);

    // ---------------- B: 0xFF then 0x00 back-to-back, mode toggling ----------------
    byte_data = 8'hFF; byte_last = 1'b0; byte_valid = 1'b1; mode_fsk = 1'b1;
    @(negedge clk);
    byte_data = 8'h00; byte_last = 1'b1;
    any_under = 1'b0;
    for (int k = 0; k <= 76; k++) begin
      if (k > 0) @(negedge clk);
      mode_fsk = ~mode_fsk;
      if (k == 40) byte_valid = 1'b0;
      if (underrun) any_under = 1'b1;
      if (k == 38) check("B_ready_before_boundary", byte_ready, 0);
      if (k == 39) check("B_ready_at_boundary", byte_ready, 1);
      if (k == 5 || k == 50) check($sformatf("B_mode_lat_k%0d", k), mode_lat, 1);
      if (k >= 8 && k < 72 && (k % 4 == 1))
        check($sformatf("B_bit_k%0d", k), bit_out, (k < 40));
      if (k == 75) check("B_done_early", frame_done, 0);
      if (k == 76) check("B_done", frame_done, 1);
    end
    check("B_no_underrun", any_under, 0);
    check("B_mode_lat_held_idle", mode_lat, 1);

    // ---------------- C: 0x81 without last, starvation ----------------
    byte_data = 8'h81; byte_last = 1'b0; byte_valid = 1'b1; mode_fsk = 1'b0;
    @(negedge clk);
    byte_valid = 1'b0;
    for (int k = 0; k <= 44; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 41) begin
        byte_valid = 1'b1; byte_data = 8'h3C; byte_last = 1'b1;
      end
      if (k == 10) check("C_mode_lat_new_frame", mode_lat, 0);
      if (k >= 8 && k < 40 && (k % 4 == 1))
        check($sformatf("C_bit_k%0d", k), bit_out, b81[7 - (k - 8) / 4]);
      check($sformatf("C_underrun_k%0d", k), underrun, (k == 40));
      if (k >= 40 && k < 44) check($sformatf("C_guard_bit_k%0d", k), bit_out, 1);
      if (k >= 41 && k < 44) check($sformatf("C_guard_holdoff_k%0d", k), byte_ready, 0);
      check($sformatf("C_done_k%0d", k), frame_done, (k == 44));
    end
    check("C_ready_idle", byte_ready, 1);

    // ---------------- D: reset mid-DATA ----------------
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (13) @(negedge clk);
    check("D_busy_before_rst", busy, 1);
    check("D_carrier_before_rst", carrier_en, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("D_rst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("D_no_done_k%0d", k), frame_done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("D_ready_after_release", byte_ready, 1);
    check("D_bit_out_idle", bit_out, 1);

`ifdef MOD_DEPTH_RAMP_EN
    // ---------------- E: depth ramp ----------------
    begin
      int  k;
      bit  seen;
      depth_tgt = 9'd180;
      byte_data = 8'h55; byte_last = 1'b0; byte_valid = 1'b1;
      @(negedge clk);
      k = 0;
      seen = 1'b0;
      while (!seen && k < 1000) begin
        @(negedge clk);
        k++;
        if (k == 150) byte_last = 1'b1;
        if (k == 170) byte_valid = 1'b0;
        if (k == 179) check("E_depth_179", depth_out, 179);
        if (k == 180) check("E_depth_180", depth_out, 180);
        if (k == 300) check("E_guard_bit", bit_out, 1);
        if (frame_done) seen = 1'b1;
      end
      check("E_done_seen", seen, 1);
      check("E_depth_zero_at_done", depth_out, 0);
      check("E_guard_extended", (k > 204), 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mod_frame_seq.md
MOD_FRAME_SEQ -- requirements
Module: mod_frame_seq

Interface
REQ-001 Parameter BIT_PERIOD, default 250000: clk cycles per transmitted bit, legal range 2..2^24.
REQ-002 Parameter PREAMBLE_BITS, default 8: alternating preamble length in bits, legal range 0..255.
REQ-003 Parameter GUARD_BITS, default 4: mark bits after frame end, legal range 1..255.
REQ-004 Parameter DEPTH_W, default 9: modulation-depth width.
REQ-005 clk  input  1  system clock, all logic rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 byte_data  input  8  payload byte.
REQ-008 byte_valid  input  1  byte_data/byte_last valid.
REQ-009 byte_last  input  1  current byte ends the frame.
REQ-010 byte_ready  output  1  byte accepted when byte_valid and byte_ready are both high on a clk edge.
REQ-011 mode_fsk  input  1  modulation mode, 0 = AM/ASK and 1 = FSK; sampled at frame start.
REQ-012 depth_tgt  input  DEPTH_W  target AM depth (unsigned).
REQ-013 bit_out  output  1  serial bit to the carrier generator.
REQ-014 bit_strobe  output  1  one-cycle pulse at each bit boundary.
REQ-015 carrier_en  output  1  carrier on.
REQ-016 mode_lat  output  1  latched mode for the current frame.
REQ-017 depth_out  output  DEPTH_W  depth to the AM adder.
REQ-018 busy  output  1  FSM not IDLE.
REQ-019 frame_done  output  1  one-cycle pulse on GUARD to IDLE.
REQ-020 underrun  output  1  one-cycle pulse on payload starvation.

Function
REQ-021 FSM states: IDLE, PREAMBLE, DATA, GUARD.
REQ-022 Bit timer: counts 0..BIT_PERIOD-1 while busy; bit_strobe is asserted when count = BIT_PERIOD-1; the counter is held at 0 in IDLE.
REQ-023 IDLE: byte_ready=1; on accept, latch the byte, mode_lat<=mode_fsk and carrier_en<=1; next state PREAMBLE, or DATA when PREAMBLE_BITS=0.
REQ-024 PREAMBLE: bit_out sequence 1,0,1,0,... starting with 1; after PREAMBLE_BITS strobes, go to DATA.
REQ-025 DATA: bytes are serialized MSB first, bit index 7 down to 0; bit_out changes only in the cycle after a strobe, or on state entry.
REQ-026 byte_ready=1 in DATA only in the cycle where bit index=0 and bit_strobe=1, and only if the held byte was not last; an accepted byte follows with no gap bit.
REQ-027 If the byte with byte_last=1 completes, go to GUARD.
REQ-028 If no byte is accepted at that boundary and last was not seen, pulse underrun and go to GUARD.
REQ-029 GUARD: bit_out=1 and carrier_en=1 for GUARD_BITS strobes; then carrier_en<=0, pulse frame_done, and go to IDLE.
REQ-030 A byte_valid arriving in GUARD is held off (byte_ready=0) until IDLE.
REQ-031 mode_fsk and byte_last are ignored except at acceptance; mode_fsk changes mid-frame have no effect.
REQ-032 depth_out is 0 whenever carrier_en=0.
REQ-033 Timer wrap: after a strobe the count returns to 0 with no lost cycle.
REQ-034 Period: every bit lasts exactly BIT_PERIOD cycles, including the first bit after IDLE.

Reset
REQ-035 While rst_n=0: state=IDLE, counters=0, bit_out=1, byte_ready=0, carrier_en=0, mode_lat=0, depth_out=0, busy=0, and all pulses=0.
REQ-036 byte_ready rises in the first cycle after reset release.
REQ-037 Reset asserted mid-frame aborts immediately, with no frame_done.

Configuration
REQ-038 Macro MOD_DEPTH_RAMP_EN defined: while carrier_en=1, depth_out steps by 1 LSB per clk toward depth_tgt, and ramps down by 1 per clk to 0 during GUARD before frame_done.
REQ-039 With the ramp, GUARD is extended until depth_out=0; bit_out stays 1 throughout.
REQ-040 Macro undefined: depth_out = registered depth_tgt while carrier_en=1, else 0, with no GUARD extension.

Structure
REQ-041 Shared package mod_pkg SHALL hold the state enum, the default BIT_PERIOD, PREAMBLE_BITS and GUARD_BITS constants, and the preamble start level.
REQ-042 Sub-module mod_bit_timer (counter plus strobe, enable input) SHALL be instantiated once.

Verification
REQ-043 BIT_PERIOD=4, PREAMBLE_BITS=2, GUARD_BITS=1, frame 0xA5 last -> bit_out 1,0 then 1,0,1,0,0,1,0,1 then 1; each bit 4 cycles; frame_done at cycle 44 after accept.
REQ-044 Two bytes 0xFF, 0x00 presented back-to-back -> second byte accepted on the 8th data strobe; no gap; bit_out shows 8 ones then 8 zeros.
REQ-045 Byte 0x81 without last and byte_valid held low -> underrun pulse at the 8th data strobe, then GUARD, then frame_done.
REQ-046 mode_fsk=1 at accept, toggled mid-frame -> mode_lat stays 1 until the next frame.
REQ-047 MOD_DEPTH_RAMP_EN, depth_tgt=180 -> depth_out reaches 180 exactly 180 cycles after carrier_en rises; returns to 0 before frame_done.
REQ-048 rst_n low mid-DATA -> all outputs take reset values within the same cycle; no frame_done.
